// File: rtl/sudoku_board_streamer.sv
// Streams the 81 board cells in row-major order over valid/ready.
// Ports: start/abort control, rd_* board-store read port, out_* stream, busy/done/bad_cell status.
module sudoku_board_streamer #(
  parameter int N      = 9,
  parameter int CELL_W = 4,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [CELL_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CELL_W-1:0] out_data,
  output logic [3:0]        out_row,
  output logic [3:0]        out_col,
  output logic              out_first,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              bad_cell
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N*N-1);
  localparam logic [3:0]        LAST_RC   = 4'(N-1);
  localparam logic [CELL_W-1:0] MAX_DIG   = CELL_W'(9);

  logic [1:0]        state;
  logic [3:0]        rd_row;
  logic [3:0]        rd_col;
  logic [3:0]        fl_row;
  logic [3:0]        fl_col;
  logic              in_flight;
  logic [CELL_W-1:0] f_data [2];
  logic [3:0]        f_row  [2];
  logic [3:0]        f_col  [2];
  logic              wptr;
  logic              rptr;
  logic [1:0]        count;
  logic              pop;
  logic [2:0]        need;

  assign out_valid = (count != 2'd0);
  assign out_data  = f_data[rptr];
  assign out_row   = f_row[rptr];
  assign out_col   = f_col[rptr];
  assign out_first = out_valid && out_row == 4'd0
                     && out_col == 4'd0;
  assign out_last  = out_valid && out_row == LAST_RC
                     && out_col == LAST_RC;
  assign busy      = (state != S_IDLE);
  assign pop       = out_valid && out_ready;

  // Slots needed if we issue now: held + pending + this one,
  // less the cell leaving this cycle.
  assign need = {1'b0, count} + {2'b0, in_flight}
              + 3'd1 - {2'b0, pop};

  assign rd_en = (state == S_STREAM) && !abort
                 && (need <= 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rd_addr   <= '0;
      rd_row    <= '0;
      rd_col    <= '0;
      fl_row    <= '0;
      fl_col    <= '0;
      in_flight <= 1'b0;
      wptr      <= 1'b0;
      rptr      <= 1'b0;
      count     <= '0;
      done      <= 1'b0;
      bad_cell  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        f_data[i] <= '0;
        f_row[i]  <= '0;
        f_col[i]  <= '0;
      end
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        if (start && !abort) begin
          state     <= S_STREAM;
          rd_addr   <= '0;
          rd_row    <= '0;
          rd_col    <= '0;
          in_flight <= 1'b0;
          wptr      <= 1'b0;
          rptr      <= 1'b0;
          count     <= '0;
          bad_cell  <= 1'b0;
        end
      end else if (abort) begin
        // Flush; any read still returning is ignored
        // because in_flight is dropped here.
        state     <= S_IDLE;
        in_flight <= 1'b0;
        wptr      <= 1'b0;
        rptr      <= 1'b0;
        count     <= '0;
      end else begin
        in_flight <= rd_en;
        if (rd_en) begin
          fl_row <= rd_row;
          fl_col <= rd_col;
          if (rd_addr == LAST_ADDR) begin
            state <= S_DRAIN;
          end else begin
            rd_addr <= rd_addr + 1'b1;
            if (rd_col == LAST_RC) begin
              rd_col <= '0;
              rd_row <= rd_row + 4'd1;
            end else begin
              rd_col <= rd_col + 4'd1;
            end
          end
        end
        if (in_flight) begin
          f_data[wptr] <= rd_data;
          f_row[wptr]  <= fl_row;
          f_col[wptr]  <= fl_col;
          wptr         <= ~wptr;
          if (rd_data > MAX_DIG) bad_cell <= 1'b1;
        end
        if (pop) rptr <= ~rptr;
        count <= count + {1'b0, in_flight}
                       - {1'b0, pop};
        if (pop && out_last && state == S_DRAIN) begin
          state <= S_IDLE;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule
